// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the core request/response channel and the data-memory bus of the
// load/store unit.
//   slave  modport : the load_store_unit view (accepts requests, drives memory)
//   master modport : the environment view (core issuing requests + data memory)
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata  core request
//   resp_valid/resp_rdata/resp_err                            core response
//   mem_address/mem_write_data/mem_MemRead/mem_MemWrite       to data memory
//   mem_read_data                                             from data memory
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_write_data, mem_MemRead, mem_MemWrite
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_address, mem_write_data, mem_MemRead, mem_MemWrite
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the data-memory interface. Accepts one load/store request
// at a time, drives MemRead/MemWrite/address/write_data into a byte-addressed
// 32-bit memory and returns a sized, sign/zero-extended load result.
// Byte/halfword stores are read-modify-write because the memory always writes
// a full 4-byte word.
//
// Parameters:
//   MEM_BYTES  data memory size; accesses with addr+size-1 >= MEM_BYTES fail
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    load_store_unit_if.slave (request/response + memory bus)
// Optional feature (compile-time macro):
//   MISALIGN_TRAP_EN  when defined, misaligned LH/LHU/SH/LW/SW return an
//                     error after one cycle without touching memory
// All outputs come straight from flops; the next-value logic works out the
// state being entered so that each output is valid for the whole state.
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 32'd65536
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Request legality: funct3 encoding, store-only restrictions, range and
    // (optionally) alignment. The range sum is 33 bits wide so an address
    // close to 2^32 cannot wrap around to a small, passing value.
    function automatic logic req_illegal(input logic        we,
                                         input logic [2:0]  f3,
                                         input logic [31:0] addr);
        logic [32:0] size_m1;
        logic [32:0] last;
        logic        bad;
        bad     = 1'b0;
        size_m1 = 33'd0;
        case (f3)
            F3_B:    size_m1 = 33'd0;
            F3_H:    size_m1 = 33'd1;
            F3_W:    size_m1 = 33'd3;
            F3_BU:   begin size_m1 = 33'd0; bad = we; end
            F3_HU:   begin size_m1 = 33'd1; bad = we; end
            default: begin size_m1 = 33'd0; bad = 1'b1; end
        endcase
        last = {1'b0, addr} + size_m1;
        if (last >= 33'(MEM_BYTES)) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
`ifdef MISALIGN_TRAP_EN
        if (((size_m1 == 33'd1) && addr[0]) ||
            ((size_m1 == 33'd3) && (addr[1:0] != 2'b00))) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
`endif
        return bad;
    endfunction

    // Load result extraction from the word read at the access address.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [31:0] w);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {{24{w[7]}}, w[7:0]};
            F3_BU:   r = {24'd0, w[7:0]};
            F3_H:    r = {{16{w[15]}}, w[15:0]};
            F3_HU:   r = {16'd0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    // Store merge: keep the untouched upper bytes of the word just read.
    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [31:0] w,
                                                input logic [31:0] wd);
        logic [31:0] r;
        case (f3)
            F3_B:    r = {w[31:8], wd[7:0]};
            F3_H:    r = {w[31:16], wd[15:0]};
            default: r = wd;
        endcase
        return r;
    endfunction

    state_t      state_r, state_s;
    logic        we_r, we_s;
    logic [2:0]  funct3_r, funct3_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic        req_ready_r, req_ready_s;
    logic        resp_valid_r, resp_valid_s;
    logic [31:0] resp_rdata_r, resp_rdata_s;
    logic        resp_err_r, resp_err_s;
    logic [31:0] mem_address_r, mem_address_s;
    logic [31:0] mem_write_data_r, mem_write_data_s;
    logic        mem_read_r, mem_read_s;
    logic        mem_write_r, mem_write_s;

    // Next state plus the registered output values for the state being entered.
    always_comb begin
        state_s          = state_r;
        we_s             = we_r;
        funct3_s         = funct3_r;
        addr_s           = addr_r;
        wdata_s          = wdata_r;
        resp_rdata_s     = 32'd0;
        resp_err_s       = 1'b0;
        mem_address_s    = mem_address_r;
        mem_write_data_s = mem_write_data_r;
        mem_read_s       = 1'b0;
        mem_write_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    we_s     = bus.req_we;
                    funct3_s = bus.req_funct3;
                    addr_s   = bus.req_addr;
                    wdata_s  = bus.req_wdata;
                    if (req_illegal(bus.req_we, bus.req_funct3, bus.req_addr)) begin
                        state_s    = DONE;
                        resp_err_s = 1'b1;
                    end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
                        // Full-word store needs no read.
                        state_s          = WR;
                        mem_write_s      = 1'b1;
                        mem_address_s    = bus.req_addr;
                        mem_write_data_s = bus.req_wdata;
                    end else begin
                        // Loads, and the read half of SB/SH.
                        state_s       = RD;
                        mem_read_s    = 1'b1;
                        mem_address_s = bus.req_addr;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RD: begin
                if (we_r) begin
                    state_s          = WR;
                    mem_write_s      = 1'b1;
                    mem_address_s    = addr_r;
                    mem_write_data_s = store_merge(funct3_r, bus.mem_read_data, wdata_r);
                end else begin
                    state_s      = DONE;
                    resp_rdata_s = load_extract(funct3_r, bus.mem_read_data);
                end
            end
            WR: begin
                state_s = DONE;
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        req_ready_s  = (state_s == IDLE);
        resp_valid_s = (state_s == DONE);
    end

    // State, latched request fields and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            we_r             <= 1'b0;
            funct3_r         <= 3'd0;
            addr_r           <= 32'd0;
            wdata_r          <= 32'd0;
            req_ready_r      <= 1'b1;
            resp_valid_r     <= 1'b0;
            resp_rdata_r     <= 32'd0;
            resp_err_r       <= 1'b0;
            mem_address_r    <= 32'd0;
            mem_write_data_r <= 32'd0;
            mem_read_r       <= 1'b0;
            mem_write_r      <= 1'b0;
        end else begin
            state_r          <= state_s;
            we_r             <= we_s;
            funct3_r         <= funct3_s;
            addr_r           <= addr_s;
            wdata_r          <= wdata_s;
            req_ready_r      <= req_ready_s;
            resp_valid_r     <= resp_valid_s;
            resp_rdata_r     <= resp_rdata_s;
            resp_err_r       <= resp_err_s;
            mem_address_r    <= mem_address_s;
            mem_write_data_r <= mem_write_data_s;
            mem_read_r       <= mem_read_s;
            mem_write_r      <= mem_write_s;
        end
    end

    assign bus.req_ready      = req_ready_r;
    assign bus.resp_valid     = resp_valid_r;
    assign bus.resp_rdata     = resp_rdata_r;
    assign bus.resp_err       = resp_err_r;
    assign bus.mem_address    = mem_address_r;
    assign bus.mem_write_data = mem_write_data_r;
    assign bus.mem_MemRead    = mem_read_r;
    assign bus.mem_MemWrite   = mem_write_r;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a byte-addressed memory model.
// Stimulus pushes expected responses (error, data, latency) and expected
// memory writes into queues; negedge monitors pop and compare them.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk;
    logic rst_n;
    load_store_unit_if bus();

    load_store_unit #(.MEM_BYTES(32'd65536)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] lat;
        logic [31:0] acc;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];

    int          errors = 0;
    int          checks = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int unsigned cyc    = 0;
    logic [7:0]  mem [0:65535];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    end

    // Memory model: unaligned little-endian 4-byte read, 4-byte write.
    always_comb begin
        bus.mem_read_data = {mem[16'(bus.mem_address + 32'd3)], mem[16'(bus.mem_address + 32'd2)],
                             mem[16'(bus.mem_address + 32'd1)], mem[16'(bus.mem_address)]};
    end

    always @(posedge clk) begin
        if (bus.mem_MemWrite) begin
            mem[16'(bus.mem_address)]         <= bus.mem_write_data[7:0];
            mem[16'(bus.mem_address + 32'd1)] <= bus.mem_write_data[15:8];
            mem[16'(bus.mem_address + 32'd2)] <= bus.mem_write_data[23:16];
            mem[16'(bus.mem_address + 32'd3)] <= bus.mem_write_data[31:24];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitors: memory-bus writes and responses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_MemRead) rd_cnt++;
            if (bus.mem_MemRead && bus.mem_MemWrite) begin
                checks++;
                errors++;
                $display("FAIL rd_wr_overlap: got both high expected exclusive");
            end
            if (bus.mem_MemWrite) begin
                wr_t w;
                wr_cnt++;
                if (wq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none",
                             bus.mem_address, bus.mem_write_data);
                end else begin
                    w = wq.pop_front();
                    chk("wr_addr", bus.mem_address, w.addr);
                    chk("wr_data", bus.mem_write_data, w.data);
                end
            end
            if (bus.resp_valid) begin
                resp_t r;
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rdata %h err %0d expected none",
                             bus.resp_rdata, bus.resp_err);
                end else begin
                    r = rq.pop_front();
                    chk("resp_err",   {31'd0, bus.resp_err}, {31'd0, r.err});
                    chk("resp_rdata", bus.resp_rdata, r.rdata);
                    chk("resp_lat",   cyc - r.acc, r.lat);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                         input int lat, input logic e_wr, input logic [31:0] e_wd);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got req_ready 0 expected 1");
        end else begin
            bus.req_valid  = 1'b1;
            bus.req_we     = we;
            bus.req_funct3 = f3;
            bus.req_addr   = a;
            bus.req_wdata  = wd;
            rq.push_back('{err: e_err, rdata: e_rd, lat: 32'(lat), acc: 32'(cyc)});
            if (e_wr) wq.push_back('{addr: a, data: e_wd});
            @(posedge clk);
            #1;
            bus.req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_resp", 32'(rq.size()), 32'd0);
        chk("drain_wr",   32'(wq.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int wr0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready",     {31'd0, bus.req_ready},    32'd1);
        chk("rst_valid",     {31'd0, bus.resp_valid},   32'd0);
        chk("rst_err",       {31'd0, bus.resp_err},     32'd0);
        chk("rst_rdata",     bus.resp_rdata,            32'd0);
        chk("rst_memread",   {31'd0, bus.mem_MemRead},  32'd0);
        chk("rst_memwrite",  {31'd0, bus.mem_MemWrite}, 32'd0);
        chk("rst_addr",      bus.mem_address,           32'd0);
        chk("rst_wdata",     bus.mem_write_data,        32'd0);

        // Reset while a store is in its WR cycle.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h0000_0300;
        bus.req_wdata  = 32'h1111_1111;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("midwr_memwrite_before", {31'd0, bus.mem_MemWrite}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midwr_memwrite_after", {31'd0, bus.mem_MemWrite}, 32'd0);
        chk("midwr_ready",          {31'd0, bus.req_ready},    32'd1);
        chk("midwr_valid",          {31'd0, bus.resp_valid},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Aborted store must not have reached memory.
        issue(1'b0, 3'b010, 32'h0000_0300, 32'd0, 1'b0, 32'h0000_0000, 2, 1'b0, 32'd0);

        // SW then LW.
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'd0, 2, 1'b1, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h0000_0100, 32'd0, 1'b0, 32'hDEAD_BEEF, 2, 1'b0, 32'd0);
        // SB read-modify-write, then LB/LBU.
        issue(1'b1, 3'b000, 32'h0000_0100, 32'hAAAA_AA12, 1'b0, 32'd0, 3, 1'b1, 32'hDEAD_BE12);
        issue(1'b0, 3'b000, 32'h0000_0100, 32'd0, 1'b0, 32'h0000_0012, 2, 1'b0, 32'd0);
        issue(1'b0, 3'b100, 32'h0000_0100, 32'd0, 1'b0, 32'h0000_0012, 2, 1'b0, 32'd0);
        // SH read-modify-write, then LW.
        issue(1'b1, 3'b001, 32'h0000_0100, 32'h5555_CAFE, 1'b0, 32'd0, 3, 1'b1, 32'hDEAD_CAFE);
        issue(1'b0, 3'b010, 32'h0000_0100, 32'd0, 1'b0, 32'hDEAD_CAFE, 2, 1'b0, 32'd0);
        // Sign/zero extension.
        issue(1'b1, 3'b010, 32'h0000_0200, 32'h0000_F080, 1'b0, 32'd0, 2, 1'b1, 32'h0000_F080);
        issue(1'b0, 3'b000, 32'h0000_0200, 32'd0, 1'b0, 32'hFFFF_FF80, 2, 1'b0, 32'd0);
        issue(1'b0, 3'b100, 32'h0000_0200, 32'd0, 1'b0, 32'h0000_0080, 2, 1'b0, 32'd0);
        issue(1'b0, 3'b001, 32'h0000_0200, 32'd0, 1'b0, 32'hFFFF_F080, 2, 1'b0, 32'd0);
        issue(1'b0, 3'b101, 32'h0000_0200, 32'd0, 1'b0, 32'h0000_F080, 2, 1'b0, 32'd0);
        drain();

        // Errors: range, illegal funct3, BU store, address wrap; no memory access.
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        issue(1'b0, 3'b010, 32'h0000_FFFD, 32'd0, 1'b1, 32'd0, 1, 1'b0, 32'd0);
        issue(1'b0, 3'b011, 32'h0000_0100, 32'd0, 1'b1, 32'd0, 1, 1'b0, 32'd0);
        issue(1'b1, 3'b100, 32'h0000_0100, 32'h0000_0055, 1'b1, 32'd0, 1, 1'b0, 32'd0);
        issue(1'b0, 3'b010, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 1, 1'b0, 32'd0);
        issue(1'b0, 3'b001, 32'h0000_FFFF, 32'd0, 1'b1, 32'd0, 1, 1'b0, 32'd0);
        drain();
        chk("err_no_memread",  32'(rd_cnt), 32'(rd0));
        chk("err_no_memwrite", 32'(wr_cnt), 32'(wr0));

        // Top-of-memory accesses that are still in range.
        issue(1'b1, 3'b010, 32'h0000_FFFC, 32'h0102_0304, 1'b0, 32'd0, 2, 1'b1, 32'h0102_0304);
        issue(1'b0, 3'b010, 32'h0000_FFFC, 32'd0, 1'b0, 32'h0102_0304, 2, 1'b0, 32'd0);
        issue(1'b0, 3'b000, 32'h0000_FFFF, 32'd0, 1'b0, 32'h0000_0001, 2, 1'b0, 32'd0);

        // Misaligned accesses over bytes FE CA AD DE 10 32 54 76 at 0x100.
        issue(1'b1, 3'b010, 32'h0000_0104, 32'h7654_3210, 1'b0, 32'd0, 2, 1'b1, 32'h7654_3210);
        issue(1'b0, 3'b100, 32'h0000_0103, 32'd0, 1'b0, 32'h0000_00DE, 2, 1'b0, 32'd0);
        issue(1'b0, 3'b000, 32'h0000_0101, 32'd0, 1'b0, 32'hFFFF_FFCA, 2, 1'b0, 32'd0);
`ifdef MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h0000_0102, 32'd0, 1'b1, 32'd0, 1, 1'b0, 32'd0);
        issue(1'b0, 3'b001, 32'h0000_0101, 32'd0, 1'b1, 32'd0, 1, 1'b0, 32'd0);
`else
        issue(1'b0, 3'b010, 32'h0000_0102, 32'd0, 1'b0, 32'h3210_DEAD, 2, 1'b0, 32'd0);
        issue(1'b0, 3'b001, 32'h0000_0101, 32'd0, 1'b0, 32'hFFFF_ADCA, 2, 1'b0, 32'd0);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
